instr_imm_encoder: RTL

Registered instruction encoder: the inverse of the immediate sign-extension path. It accepts decoded instruction fields plus a 32-bit immediate and a format code, and packs them into a 32-bit RV32I instruction word. It range-checks the immediate against the format, tags each word with its instruction-memory address, and emits it over a valid/ready stream. It sits in the program-loader/self-test path, feeding instruction memory or a trace checker.

---
 rtl/instr_imm_encoder.sv | 113 +++++++++++
 1 files changed

// File: rtl/instr_imm_encoder.sv
// Registered RV32I instruction encoder: packs decoded fields and an immediate into an
// instruction word, flags immediates the chosen format cannot represent, and streams it out.
module instr_imm_encoder #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            immsrc,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [6:0]            funct7,
    input  logic [31:0]           imm,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [31:0]           out_instr,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  out_err,
    output logic [15:0]           err_count,
    output logic [15:0]           instr_count
);

    localparam logic [2:0]  FMT_I     = 3'b000;
    localparam logic [2:0]  FMT_S     = 3'b001;
    localparam logic [2:0]  FMT_B     = 3'b010;
    localparam logic [2:0]  FMT_J     = 3'b011;
    localparam logic [2:0]  FMT_U     = 3'b100;
    localparam logic [2:0]  FMT_ISH   = 3'b101;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic [31:0]           instr_c;
    logic                  err_c;
    logic                  accept_c;
    logic [ADDR_WIDTH-1:0] next_addr;

    // An immediate fits N signed bits when all bits from N-1 upward agree with the sign.
    logic fits12_c, fits13_c, fits21_c;
    assign fits12_c = (&imm[31:11]) | ~(|imm[31:11]);
    assign fits13_c = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits21_c = (&imm[31:20]) | ~(|imm[31:20]);

    assign in_ready = !out_valid || out_ready;
    assign accept_c = in_valid && in_ready;

    // Field packing and range check; out-of-range words are still packed with truncated fields.
    always_comb begin
        instr_c = NOP_INSTR;
        err_c   = 1'b1;
        case (immsrc)
            FMT_I: begin
                instr_c = {imm[11:0], rs1, funct3, rd, opcode};
                err_c   = !fits12_c;
            end
            FMT_S: begin
                instr_c = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
                err_c   = !fits12_c;
            end
            FMT_B: begin
                instr_c = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                err_c   = !fits13_c || imm[0];
            end
            FMT_J: begin
                instr_c = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err_c   = !fits21_c || imm[0];
            end
            FMT_U: begin
                instr_c = {imm[31:12], rd, opcode};
                err_c   = |imm[11:0];
            end
            FMT_ISH: begin
                instr_c = {funct7, imm[4:0], rs1, funct3, rd, opcode};
                err_c   = |imm[31:5];
            end
            default: begin
                instr_c = NOP_INSTR;
                err_c   = 1'b1;
            end
        endcase
    end

    // Output register, address counter and statistics; reset drops any pending word.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid   <= 1'b0;
            out_instr   <= '0;
            out_addr    <= BASE_ADDR;
            out_err     <= 1'b0;
            err_count   <= '0;
            instr_count <= '0;
            next_addr   <= BASE_ADDR;
        end else begin
            if (accept_c) begin
                out_valid   <= 1'b1;
                out_instr   <= instr_c;
                out_err     <= err_c;
                out_addr    <= next_addr;
                next_addr   <= next_addr + ADDR_WIDTH'(4);
                instr_count <= instr_count + 16'd1;
                if (err_c && (err_count != 16'hFFFF)) begin
                    err_count <= err_count + 16'd1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
